// File: rtl/cdb_arbiter_pkg.sv
// Shared constants, the CDB broadcast packet type and index helpers for the
// common-data-bus arbiter.
//   N_WAY / CDB_N_CDB : CDB lanes per cycle
//   CDB_N_REQ         : requesting functional units
//   CDB_BITS          : physical tag width (tag 0 = no destination)
//   CDB_XLEN          : result width
package cdb_arbiter_pkg;

  localparam int unsigned N_WAY     = 2;
  localparam int unsigned CDB_N_CDB = N_WAY;
  localparam int unsigned CDB_N_REQ = 4;
  localparam int unsigned CDB_BITS  = 6;
  localparam int unsigned CDB_XLEN  = 32;
  localparam int unsigned CDB_SRC_W = (CDB_N_REQ > 1) ? $clog2(CDB_N_REQ) : 1;

  typedef struct packed {
    logic                 valid;
    logic [CDB_BITS-1:0]  tag;
    logic [CDB_XLEN-1:0]  data;
    logic [CDB_SRC_W-1:0] src;
  } cdb_packet_t;

  // Increment an index modulo n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/broadcast bundle between the functional units and the CDB arbiter.
//   req_valid/req_tag/req_data : FU completed result (flattened per FU)
//   req_ready                  : combinational grant back to each FU
//   cdb_valid/tag/data/src     : registered lane broadcast (flattened per lane)
// Modports: master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = CDB_N_REQ,
  parameter int unsigned N_CDB = CDB_N_CDB,
  parameter int unsigned TAG_W = CDB_BITS,
  parameter int unsigned XLEN  = CDB_XLEN
);
  localparam int unsigned SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic [N_REQ*XLEN-1:0]  req_data;
  logic [N_REQ-1:0]       req_ready;
  logic [N_CDB-1:0]       cdb_valid;
  logic [N_CDB*TAG_W-1:0] cdb_tag;
  logic [N_CDB*XLEN-1:0]  cdb_data;
  logic [N_CDB*SRC_W-1:0] cdb_src;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick_n.sv
// Combinational round-robin picker: scans req_i starting at start_i, wrapping
// modulo N_REQ, and selects the first up to N_CDB set bits.
//   req_i      : candidate mask
//   start_i    : scan start index
//   grant_o    : mask of selected candidates
//   lane_hit_o : lane k holds a winner
//   lane_idx_o : index of the k-th winner in scan order
//   last_idx_o : index of the last winner (valid when any_o)
//   any_o      : at least one winner
module rr_pick_n
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = CDB_N_REQ,
  parameter int unsigned N_CDB = CDB_N_CDB,
  parameter int unsigned IDXW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0]           req_i,
  input  logic [IDXW-1:0]            start_i,
  output logic [N_REQ-1:0]           grant_o,
  output logic [N_CDB-1:0]           lane_hit_o,
  output logic [N_CDB-1:0][IDXW-1:0] lane_idx_o,
  output logic [IDXW-1:0]            last_idx_o,
  output logic                       any_o
);

  int unsigned pos;
  int unsigned cnt;

  // Index compares instead of variable bit-selects keep the scan legal for
  // any N_REQ, including non-powers of two.
  always_comb begin
    grant_o    = '0;
    lane_hit_o = '0;
    lane_idx_o = '0;
    last_idx_o = '0;
    any_o      = 1'b0;
    cnt        = 0;
    pos        = 32'(start_i);
    for (int unsigned s = 0; s < N_REQ; s++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (i == pos && req_i[i] && cnt < N_CDB) begin
          grant_o[i] = 1'b1;
          for (int unsigned k = 0; k < N_CDB; k++) begin
            if (k == cnt) begin
              lane_hit_o[k] = 1'b1;
              lane_idx_o[k] = IDXW'(i);
            end
          end
          last_idx_o = IDXW'(i);
          any_o      = 1'b1;
          cnt        = cnt + 1;
        end
      end
      pos = wrap_inc(pos, N_REQ);
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: shares N_CDB registered broadcast lanes among
// N_REQ completing functional units with a round-robin multi-grant scheme.
//   clock     : system clock
//   reset     : synchronous, active-low
//   squash    : branch hazard; blocks grants and empties the lanes next edge
//   bus       : FU requests in, req_ready out, registered CDB lanes out
//   stall_cnt : saturating count of cycles with more live requests than lanes
// Zero-tag requests are acknowledged immediately without using a lane or
// moving the round-robin pointer.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = CDB_N_REQ,
  parameter int unsigned N_CDB = CDB_N_CDB,
  parameter int unsigned TAG_W = CDB_BITS,
  parameter int unsigned XLEN  = CDB_XLEN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         squash,
  cdb_arbiter_if.slave bus,
  output logic [15:0]  stall_cnt
);

  localparam int unsigned IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
    logic [IDXW-1:0]  src;
  } lane_t;

  logic [N_REQ-1:0]           tag_live;
  logic [N_REQ-1:0]           tag_zero;
  logic [N_REQ-1:0]           grant;
  logic [N_CDB-1:0]           lane_hit;
  logic [N_CDB-1:0][IDXW-1:0] lane_idx;
  logic [IDXW-1:0]            last_idx;
  logic                       any_grant;
  logic                       active;
  int unsigned                live_cnt;

  logic [IDXW-1:0]            rr_ptr_q, rr_ptr_d;
  lane_t [N_CDB-1:0]          lane_q, lane_d;
  logic [15:0]                stall_cnt_q, stall_cnt_d;

  // Split valid requests into lane-needing (non-zero tag) and pass-through.
  always_comb begin
    tag_live = '0;
    tag_zero = '0;
    live_cnt = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (bus.req_valid[i]) begin
        if (bus.req_tag[i*TAG_W +: TAG_W] == '0) begin
          tag_zero[i] = 1'b1;
        end else begin
          tag_live[i] = 1'b1;
          live_cnt    = live_cnt + 1;
        end
      end
    end
  end

  rr_pick_n #(
    .N_REQ (N_REQ),
    .N_CDB (N_CDB),
    .IDXW  (IDXW)
  ) u_pick (
    .req_i      (tag_live),
    .start_i    (rr_ptr_q),
    .grant_o    (grant),
    .lane_hit_o (lane_hit),
    .lane_idx_o (lane_idx),
    .last_idx_o (last_idx),
    .any_o      (any_grant)
  );

  assign active        = reset && !squash;
  assign bus.req_ready = active ? (grant | tag_zero) : '0;

  always_comb begin
    lane_d = '0;
    for (int unsigned k = 0; k < N_CDB; k++) begin
      if (active && lane_hit[k]) begin
        lane_d[k].valid = 1'b1;
        lane_d[k].src   = lane_idx[k];
        for (int unsigned i = 0; i < N_REQ; i++) begin
          if (lane_idx[k] == IDXW'(i)) begin
            lane_d[k].tag  = bus.req_tag[i*TAG_W +: TAG_W];
            lane_d[k].data = bus.req_data[i*XLEN +: XLEN];
          end
        end
      end
    end

    rr_ptr_d = rr_ptr_q;
    if (active && any_grant) begin
      rr_ptr_d = IDXW'(wrap_inc(32'(last_idx), N_REQ));
    end

    stall_cnt_d = stall_cnt_q;
    if (!squash && live_cnt > N_CDB && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      lane_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lane_q      <= lane_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    bus.cdb_valid = '0;
    bus.cdb_tag   = '0;
    bus.cdb_data  = '0;
    bus.cdb_src   = '0;
    for (int unsigned k = 0; k < N_CDB; k++) begin
      bus.cdb_valid[k]                = lane_q[k].valid;
      bus.cdb_tag[k*TAG_W +: TAG_W]   = lane_q[k].tag;
      bus.cdb_data[k*XLEN +: XLEN]    = lane_q[k].data;
      bus.cdb_src[k*IDXW +: IDXW]     = lane_q[k].src;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
